// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write/lock/clear controls plus two combinational read ports.
// master = datapath side, slave = register file.
interface reg_file_sb_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  d_in;
  logic              lock;
  logic [ADDR_W-1:0] lock_addr;
  logic              clr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  d_out_a;
  logic [WIDTH-1:0]  d_out_b;
  logic              busy_a;
  logic              busy_b;
  logic              clr_busy;

  modport master (
    output wr, wr_addr, d_in, lock, lock_addr, clr, rd_addr_a, rd_addr_b,
    input  d_out_a, d_out_b, busy_a, busy_b, clr_busy
  );

  modport slave (
    input  wr, wr_addr, d_in, lock, lock_addr, clr, rd_addr_a, rd_addr_b,
    output d_out_a, d_out_b, busy_a, busy_b, clr_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// 2R/1W register file with per-register busy scoreboard and a one-register-per-cycle bulk clear.
// Optional macro REG_FILE_BYPASS_EN forwards an accepted write to matching read ports in the same cycle.
module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              idle, wr_acc, lk_acc;

  assign idle   = (state_q == S_IDLE);
  assign wr_acc = idle && bus.wr   && !(ZR && (bus.wr_addr   == '0));
  assign lk_acc = idle && bus.lock && !(ZR && (bus.lock_addr == '0));

  always_comb begin
    busy_d  = busy_q;
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_IDLE) begin
      // lock is applied after the write so a same-address wr+lock leaves the register busy
      if (wr_acc) busy_d[bus.wr_addr] = 1'b0;
      if (lk_acc) busy_d[bus.lock_addr] = 1'b1;
      if (bus.clr) begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    end else begin
      busy_d[idx_q] = 1'b0;
      idx_d         = idx_q + 1'b1;
      if (idx_q == ADDR_W'(DEPTH - 1)) state_d = S_IDLE;
    end
    if (ZR) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      mem_q[idx_q] <= '0;
    end else if (wr_acc) begin
      mem_q[bus.wr_addr] <= bus.d_in;
    end
  end

  always_comb begin
    bus.d_out_a = mem_q[bus.rd_addr_a];
    bus.busy_a  = busy_q[bus.rd_addr_a];
    bus.d_out_b = mem_q[bus.rd_addr_b];
    bus.busy_b  = busy_q[bus.rd_addr_b];
    if (ZR && (bus.rd_addr_a == '0)) begin
      bus.d_out_a = '0;
      bus.busy_a  = 1'b0;
    end
    if (ZR && (bus.rd_addr_b == '0)) begin
      bus.d_out_b = '0;
      bus.busy_b  = 1'b0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_acc && (bus.rd_addr_a == bus.wr_addr)) begin
      bus.d_out_a = bus.d_in;
      bus.busy_a  = bus.lock && (bus.lock_addr == bus.wr_addr);
    end
    if (wr_acc && (bus.rd_addr_b == bus.wr_addr)) begin
      bus.d_out_b = bus.d_in;
      bus.busy_b  = bus.lock && (bus.lock_addr == bus.wr_addr);
    end
`else
`endif
  end

  assign bus.clr_busy = (state_q == S_CLEAR);
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected read-port values, a negedge monitor compares.
// Two instances share clk/reset: dut_a with ZERO_REG=0, dut_z with ZERO_REG=1.
module tb_reg_file_sb;
  localparam int K_DA = 0, K_DB = 1, K_BA = 2, K_BB = 3, K_CB = 4;

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    logic [15:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  chk_t sb_q[$];

  always #5 clk = ~clk;

  reg_file_sb_if #(.WIDTH(16), .ADDR_W(3)) ifa ();
  reg_file_sb_if #(.WIDTH(16), .ADDR_W(3)) ifz ();

  reg_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  reg_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (.clk(clk), .reset(reset), .bus(ifz.slave));

  task automatic push(input string name, input int dut, input int kind, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.dut  = dut;
    c.kind = kind;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  function automatic logic [15:0] actual(input int dut, input int kind);
    logic [15:0] v;
    v = 16'hxxxx;
    if (dut == 0) begin
      case (kind)
        K_DA: v = ifa.d_out_a;
        K_DB: v = ifa.d_out_b;
        K_BA: v = {15'd0, ifa.busy_a};
        K_BB: v = {15'd0, ifa.busy_b};
        default: v = {15'd0, ifa.clr_busy};
      endcase
    end else begin
      case (kind)
        K_DA: v = ifz.d_out_a;
        K_DB: v = ifz.d_out_b;
        K_BA: v = {15'd0, ifz.busy_a};
        K_BB: v = {15'd0, ifz.busy_b};
        default: v = {15'd0, ifz.clr_busy};
      endcase
    end
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() != 0) begin
        chk_t        c;
        logic [15:0] a;
        c = sb_q.pop_front();
        a = actual(c.dut, c.kind);
        n_chk++;
        if (a !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
        end
      end
    end
  end

  task automatic idle();
    ifa.wr = 0; ifa.wr_addr = 0; ifa.d_in = 0; ifa.lock = 0; ifa.lock_addr = 0;
    ifa.clr = 0; ifa.rd_addr_a = 0; ifa.rd_addr_b = 0;
    ifz.wr = 0; ifz.wr_addr = 0; ifz.d_in = 0; ifz.lock = 0; ifz.lock_addr = 0;
    ifz.clr = 0; ifz.rd_addr_a = 0; ifz.rd_addr_b = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr_a(input logic [2:0] addr, input logic [15:0] data);
    ifa.wr = 1; ifa.wr_addr = addr; ifa.d_in = data;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state on every register
    for (int i = 0; i < 8; i++) begin
      cyc();
      ifa.rd_addr_a = 3'(i); ifa.rd_addr_b = 3'(7 - i);
      push("rst_dout_a", 0, K_DA, 16'h0000);
      push("rst_dout_b", 0, K_DB, 16'h0000);
      push("rst_busy_a", 0, K_BA, 16'h0000);
      push("rst_busy_b", 0, K_BB, 16'h0000);
      push("rst_clr_busy", 0, K_CB, 16'h0000);
    end

    cyc(); wr_a(3'd3, 16'hcdef);
    cyc(); ifa.rd_addr_a = 3'd3; ifa.rd_addr_b = 3'd3;
    push("wr_r3_a", 0, K_DA, 16'hcdef);
    push("wr_r3_b", 0, K_DB, 16'hcdef);
    push("wr_r3_busy", 0, K_BA, 16'h0000);

    cyc(); ifa.lock = 1; ifa.lock_addr = 3'd5;
    cyc(); ifa.rd_addr_a = 3'd5;
    push("lock_r5_busy", 0, K_BA, 16'h0001);
    push("lock_r5_data", 0, K_DA, 16'h0000);
    cyc(); wr_a(3'd5, 16'h4567);
    cyc(); ifa.rd_addr_a = 3'd5;
    push("wr_r5_unbusy", 0, K_BA, 16'h0000);
    push("wr_r5_data", 0, K_DA, 16'h4567);
    cyc(); wr_a(3'd5, 16'h89ab); ifa.lock = 1; ifa.lock_addr = 3'd5;
    cyc(); ifa.rd_addr_a = 3'd5;
    push("wrlock_r5_busy", 0, K_BA, 16'h0001);
    push("wrlock_r5_data", 0, K_DA, 16'h89ab);

    cyc(); wr_a(3'd1, 16'h1111); ifa.lock = 1; ifa.lock_addr = 3'd2;
    cyc(); ifa.rd_addr_a = 3'd1; ifa.rd_addr_b = 3'd2;
    push("split_wr_data", 0, K_DA, 16'h1111);
    push("split_wr_busy", 0, K_BA, 16'h0000);
    push("split_lock_busy", 0, K_BB, 16'h0001);
    push("split_lock_data", 0, K_DB, 16'h0000);

    // bulk clear over a full file, with writes/locks issued mid-clear
    for (int i = 0; i < 8; i++) begin
      cyc(); wr_a(3'(i), 16'hffff);
    end
    cyc(); ifa.clr = 1;
    push("clr_accept_cb", 0, K_CB, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      cyc();
      push("clr_busy_hi", 0, K_CB, 16'h0001);
      if (k == 4) begin
        wr_a(3'd2, 16'h1234);
        ifa.lock = 1; ifa.lock_addr = 3'd6;
      end
    end
    cyc();
    push("clr_busy_lo", 0, K_CB, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      cyc(); ifa.rd_addr_a = 3'(i); ifa.rd_addr_b = 3'(i);
      push("clr_data", 0, K_DA, 16'h0000);
      push("clr_busy_bit", 0, K_BA, 16'h0000);
    end

    // hardwired zero register versus a normal r0
    cyc();
    ifz.wr = 1; ifz.wr_addr = 3'd0; ifz.d_in = 16'hba98;
    ifz.lock = 1; ifz.lock_addr = 3'd0; ifz.rd_addr_a = 3'd0;
    wr_a(3'd0, 16'hba98);
    push("zr_same_cycle_data", 1, K_DA, 16'h0000);
    push("zr_same_cycle_busy", 1, K_BA, 16'h0000);
    cyc(); ifz.rd_addr_a = 3'd0; ifz.rd_addr_b = 3'd0; ifa.rd_addr_a = 3'd0;
    ifz.wr = 1; ifz.wr_addr = 3'd1; ifz.d_in = 16'h7777;
    push("zr_r0_data", 1, K_DA, 16'h0000);
    push("zr_r0_busy", 1, K_BA, 16'h0000);
    push("zr_r0_busy_b", 1, K_BB, 16'h0000);
    push("nzr_r0_data", 0, K_DA, 16'hba98);
    cyc(); ifz.rd_addr_a = 3'd1;
    push("zr_r1_data", 1, K_DA, 16'h7777);

    // reset during the fourth clear cycle
    for (int i = 0; i < 8; i++) begin
      cyc(); wr_a(3'(i), 16'h1000 + 16'(i));
    end
    cyc(); ifa.clr = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      push("rclr_busy_hi", 0, K_CB, 16'h0001);
    end
    reset = 1'b1;
    cyc(); reset = 1'b0;
    push("rclr_busy_lo", 0, K_CB, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      cyc(); ifa.rd_addr_a = 3'(i);
      push("rclr_data", 0, K_DA, 16'h0000);
    end

    // same-cycle read of a register being written
    cyc(); wr_a(3'd4, 16'hadef); ifa.rd_addr_a = 3'd4; ifa.rd_addr_b = 3'd4;
`ifdef REG_FILE_BYPASS_EN
    push("byp_data_a", 0, K_DA, 16'hadef);
    push("byp_data_b", 0, K_DB, 16'hadef);
`else
    push("nobyp_data_a", 0, K_DA, 16'h0000);
    push("nobyp_data_b", 0, K_DB, 16'h0000);
`endif
    push("byp_busy_a", 0, K_BA, 16'h0000);
    cyc(); wr_a(3'd4, 16'h5a5a); ifa.lock = 1; ifa.lock_addr = 3'd4; ifa.rd_addr_a = 3'd4;
`ifdef REG_FILE_BYPASS_EN
    push("byp_lock_data", 0, K_DA, 16'h5a5a);
    push("byp_lock_busy", 0, K_BA, 16'h0001);
`else
    push("nobyp_lock_data", 0, K_DA, 16'hadef);
    push("nobyp_lock_busy", 0, K_BA, 16'h0000);
`endif
    cyc(); ifa.rd_addr_a = 3'd4;
    push("after_lock_data", 0, K_DA, 16'h5a5a);
    push("after_lock_busy", 0, K_BA, 16'h0001);

    cyc();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
